// File: rtl/hack_loader_pkg.sv
// hack_loader_pkg: shared types and helpers for the HACK serial ROM loader.
// Optional feature macro used by the loader: HACK_LOADER_CHECKSUM_EN.
package hack_loader_pkg;

  // Frame parser states
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM
  } state_t;

  // Start-of-frame marker
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Number of serial bytes that carry one ROM word
  function automatic int calc_bpw(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/hack_loader_timer.sv
// hack_loader_timer: inter-byte watchdog for the loader.
// expired asserts once TIMEOUT_CYCLES consecutive cycles have passed with
// enable high and no kick; a kick in the expiry cycle itself reloads it.
module hack_loader_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;

  // Count silent cycles while a frame is open; saturate at the expiry value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (kick || !enable) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // The count starts at 0 in the first silent cycle, so TIMEOUT_CYCLES-1
  // marks the TIMEOUT_CYCLES-th silent cycle.
  assign expired = enable && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: frames the UART byte stream (SYNC, LEN_HI, LEN_LO, data,
// optional CSUM), assembles big-endian words and writes them to HACK ROM
// with an auto-incrementing address while holding the CPU in reset.
// Optional feature macro: HACK_LOADER_CHECKSUM_EN (trailing 8-bit sum byte).
module hack_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int          BPW   = calc_bpw(DATA_W);
  localparam int          WW    = BPW * 8;
  localparam int          BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  state_t            state_reg;
  logic [7:0]        len_hi_reg;
  logic [15:0]       words_rem_reg;
  logic [BCW-1:0]    byte_cnt_reg;
  logic [WW-1:0]     word_reg;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [DATA_W-1:0] rom_data_reg;
  logic              rom_we_reg;
  logic              cpu_hold_reg;
  logic              load_done_reg;
  logic              load_err_reg;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg;
`endif

  logic [WW-1:0] word_next;
  logic [15:0]   len_word;
  logic          last_byte;
  logic          timer_expired;

  // Shift the new byte in at the bottom; the oldest byte falls off the top
  assign word_next = WW'({word_reg, rx_data});
  assign len_word  = {len_hi_reg, rx_data};
  assign last_byte = (byte_cnt_reg == BCW'(BPW - 1));

  hack_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (state_reg != IDLE),
    .kick   (rx_valid),
    .expired(timer_expired)
  );

  // Frame parser, word assembly and registered ROM/CPU control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_hi_reg    <= '0;
      words_rem_reg <= '0;
      byte_cnt_reg  <= '0;
      word_reg      <= '0;
      rom_addr_reg  <= '0;
      rom_data_reg  <= '0;
      rom_we_reg    <= 1'b0;
      cpu_hold_reg  <= 1'b0;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      rom_we_reg    <= 1'b0;
      load_done_reg <= 1'b0;
      // Address moves on the cycle after the strobe so it is stable during it
      if (rom_we_reg) begin
        rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
      end
      if (state_reg != IDLE && !rx_valid && timer_expired) begin
        load_err_reg <= 1'b1;
        state_reg    <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              state_reg    <= LEN_HI;
              load_err_reg <= 1'b0;
              cpu_hold_reg <= 1'b1;
              rom_addr_reg <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
              csum_reg     <= '0;
`endif
            end
          end
          LEN_HI: begin
            if (rx_valid) begin
              len_hi_reg <= rx_data;
              state_reg  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (rx_valid) begin
              byte_cnt_reg  <= '0;
              words_rem_reg <= len_word;
              if (len_word == 16'd0) begin
`ifdef HACK_LOADER_CHECKSUM_EN
                state_reg     <= CSUM;
`else
                load_done_reg <= 1'b1;
                cpu_hold_reg  <= 1'b0;
                state_reg     <= IDLE;
`endif
              end else if ({17'd0, len_word} > DEPTH) begin
                load_err_reg <= 1'b1;
                state_reg    <= IDLE;
              end else begin
                state_reg <= DATA;
              end
            end
          end
          DATA: begin
            if (rx_valid) begin
              word_reg <= word_next;
`ifdef HACK_LOADER_CHECKSUM_EN
              csum_reg <= csum_reg + rx_data;
`endif
              if (last_byte) begin
                byte_cnt_reg  <= '0;
                rom_we_reg    <= 1'b1;
                rom_data_reg  <= word_next[DATA_W-1:0];
                words_rem_reg <= words_rem_reg - 16'd1;
                if (words_rem_reg == 16'd1) begin
`ifdef HACK_LOADER_CHECKSUM_EN
                  state_reg     <= CSUM;
`else
                  load_done_reg <= 1'b1;
                  cpu_hold_reg  <= 1'b0;
                  state_reg     <= IDLE;
`endif
                end
              end else begin
                byte_cnt_reg <= byte_cnt_reg + BCW'(1);
              end
            end
          end
          CSUM: begin
`ifdef HACK_LOADER_CHECKSUM_EN
            if (rx_valid) begin
              if (rx_data == csum_reg) begin
                load_done_reg <= 1'b1;
                cpu_hold_reg  <= 1'b0;
              end else begin
                load_err_reg <= 1'b1;
              end
              state_reg <= IDLE;
            end
`else
            state_reg <= IDLE;
`endif
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign rom_data  = rom_data_reg;
  assign rom_we    = rom_we_reg;
  assign cpu_hold  = cpu_hold_reg;
  assign load_done = load_done_reg;
  assign load_err  = load_err_reg;

endmodule
